// File: rtl/bcd_to_bin.sv
// bcd_to_bin: six-digit BCD to 20-bit binary converter.
// Uses reverse double-dabble on a 44-bit register {BCD[43:20], binary[19:0]}.
// Each conversion takes 20 shift/correct steps. A one-cycle done pulse marks
// bin/err valid, and both hold their values until the next done.
// Optional feature: define BCD2BIN_DIGIT_CHECK_EN to flag digits greater than 9.
// An invalid input then returns bin=0 with err=1.
module bcd_to_bin (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  data0,
    input  logic [3:0]  data1,
    input  logic [3:0]  data2,
    input  logic [3:0]  data3,
    input  logic [3:0]  data4,
    input  logic [3:0]  data5,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [19:0] bin,
    output logic        err
);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam logic [4:0] LAST_STEP = 5'd19;

    state_t      state_q, state_d;
    logic [43:0] sr_q, sr_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [19:0] bin_q, bin_d;
    logic [43:0] sr_step;

`ifdef BCD2BIN_DIGIT_CHECK_EN
    logic        bad_q, bad_d;
    logic        err_q, err_d;
    logic        any_bad;
`endif

    // One reverse double-dabble step: shift right, then pull every BCD
    // nibble that reached 8 or more back down by 3.
    function automatic logic [43:0] dabble_step(input logic [43:0] v);
        logic [43:0] s;
        s = v >> 1;
        for (int unsigned i = 0; i < 6; i++) begin
            if (s[20 + 4*i +: 4] >= 4'd8) begin
                s[20 + 4*i +: 4] = s[20 + 4*i +: 4] - 4'd3;
            end
        end
        return s;
    endfunction

    // Combinational shift/correct applied to the current register.
    always_comb begin
        sr_step = dabble_step(sr_q);
    end

`ifdef BCD2BIN_DIGIT_CHECK_EN
    // Flags any input digit outside 0..9 while the digits are being accepted.
    always_comb begin
        any_bad = (data0 > 4'd9) || (data1 > 4'd9) || (data2 > 4'd9) ||
                  (data3 > 4'd9) || (data4 > 4'd9) || (data5 > 4'd9);
    end
`endif

    // Next-state logic for the FSM, the datapath and the result registers.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        bin_d   = bin_q;
`ifdef BCD2BIN_DIGIT_CHECK_EN
        bad_d   = bad_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = {data5, data4, data3, data2, data1, data0, 20'd0};
                    cnt_d   = '0;
                    state_d = CONV;
`ifdef BCD2BIN_DIGIT_CHECK_EN
                    bad_d   = any_bad;
`endif
                end
            end
            CONV: begin
                sr_d  = sr_step;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_STEP) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
`ifdef BCD2BIN_DIGIT_CHECK_EN
                    bin_d   = bad_q ? '0 : sr_step[19:0];
                    err_d   = bad_q;
`else
                    bin_d   = sr_step[19:0];
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, asynchronously cleared by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            bin_q   <= '0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            bad_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            bin_q   <= bin_d;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            bad_q   <= bad_d;
            err_q   <= err_d;
`endif
        end
    end

    assign busy = (state_q == CONV);
    assign done = done_q;
    assign bin  = bin_q;
`ifdef BCD2BIN_DIGIT_CHECK_EN
    assign err  = err_q;
`else
    assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin.sv
// Testbench for bcd_to_bin. A countdown model computes each result as a plain
// decimal sum. The model and the outputs are compared on every falling edge.
// Directed cases pin the expected values with literal numbers.
module tb_bcd_to_bin;

    logic        clk;
    logic        rst_n;
    logic [3:0]  data0, data1, data2, data3, data4, data5;
    logic        start;
    logic        busy, done, err;
    logic [19:0] bin;

    int vectors;
    int miscompares;

    bcd_to_bin dut (
        .clk   (clk),
        .rst_n (rst_n),
        .data0 (data0),
        .data1 (data1),
        .data2 (data2),
        .data3 (data3),
        .data4 (data4),
        .data5 (data5),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bin   (bin),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          m_cnt;     // CONV cycles still to run (0 = idle)
    int          m_val;
    logic        m_bad;
    logic        m_done;
    logic [19:0] m_bin;
    logic        m_err;

    function automatic int dec_value(input logic [3:0] d5, d4, d3, d2, d1, d0);
        return d5*100000 + d4*10000 + d3*1000 + d2*100 + d1*10 + int'(d0);
    endfunction

    function automatic logic digits_bad(input logic [3:0] d5, d4, d3, d2, d1, d0);
`ifdef BCD2BIN_DIGIT_CHECK_EN
        return (d5 > 9) || (d4 > 9) || (d3 > 9) || (d2 > 9) || (d1 > 9) || (d0 > 9);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= 0;
            m_val  <= 0;
            m_bad  <= 1'b0;
            m_done <= 1'b0;
            m_bin  <= '0;
            m_err  <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt == 0) begin
                if (start) begin
                    m_cnt <= 20;
                    m_val <= dec_value(data5, data4, data3, data2, data1, data0);
                    m_bad <= digits_bad(data5, data4, data3, data2, data1, data0);
                end
            end else begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_done <= 1'b1;
                    m_bin  <= m_bad ? 20'd0 : m_val[19:0];
                    m_err  <= m_bad;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("busy", {31'd0, busy}, {31'd0, (m_cnt != 0)});
        chk("done", {31'd0, done}, {31'd0, m_done});
        chk("bin",  {12'd0, bin},  {12'd0, m_bin});
        chk("err",  {31'd0, err},  {31'd0, m_err});
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_digits(input logic [3:0] d5, d4, d3, d2, d1, d0);
        data5 = d5; data4 = d4; data3 = d3; data2 = d2; data1 = d1; data0 = d0;
    endtask

    // Waits for done and returns the number of falling edges that were consumed.
    // The count includes the edge on which done is seen (max 40).
    task automatic wait_done(input string name, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 40);
        if (!done) begin
            miscompares++;
            vectors++;
            $display("FAIL %s_timeout: got no done, expected done within 40 cycles", name);
        end
    endtask

    // Drives start for one cycle with the given digits and waits for done.
    // If start is driven before edge k, done is seen on the 21st falling edge.
    task automatic conv(input string name, input logic [3:0] d5, d4, d3, d2, d1, d0,
                        input logic [19:0] exp_bin, input logic exp_err);
        int n;
        set_digits(d5, d4, d3, d2, d1, d0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(name, n);
        chk({name, "_lat"}, n + 1, 21);
        chk({name, "_bin"}, {12'd0, bin}, {12'd0, exp_bin});
        chk({name, "_err"}, {31'd0, err}, {31'd0, exp_err});
    endtask

    initial begin
        int n;
        int dones;
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        start = 1'b0;
        set_digits(0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_bin",  {12'd0, bin},  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        conv("c123456", 1, 2, 3, 4, 5, 6, 20'h1E240, 1'b0);
        conv("c999999", 9, 9, 9, 9, 9, 9, 20'hF423F, 1'b0);
        conv("c000000", 0, 0, 0, 0, 0, 0, 20'h00000, 1'b0);

        // Back-to-back conversions, with a stray start pulse while busy.
        set_digits(0, 0, 0, 0, 4, 2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("b2b_a", n);
        chk("b2b_a_bin", {12'd0, bin}, 32'd42);
        set_digits(0, 0, 0, 1, 0, 0);
        start = 1'b1;                 // accepted on the edge that ends the done cycle
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        set_digits(9, 9, 9, 9, 9, 9);
        start = 1'b1;                 // ignored: conversion in progress
        @(negedge clk);
        start = 1'b0;
        n = 7;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_spacing", n, 21);
        chk("b2b_b_bin", {12'd0, bin}, 32'd100);
        dones = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("b2b_no_extra_done", dones, 0);

        // Input digits change mid-conversion; the result must not follow them.
        set_digits(1, 2, 3, 4, 5, 6);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        set_digits(7, 7, 7, 7, 7, 7);
        wait_done("hold_in", n);
        chk("hold_in_bin", {12'd0, bin}, 32'h1E240);

        // Reset in the middle of a conversion aborts it.
        set_digits(0, 0, 0, 0, 0, 9);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_bin",  {12'd0, bin},  32'd0);
        rst_n = 1'b1;
        dones = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("abort_no_done", dones, 0);
        conv("c000001", 0, 0, 0, 0, 0, 1, 20'd1, 1'b0);

`ifdef BCD2BIN_DIGIT_CHECK_EN
        conv("bad_digit", 0, 0, 0, 4'hA, 0, 0, 20'd0, 1'b1);
        conv("after_bad", 0, 0, 0, 0, 0, 5, 20'd5, 1'b0);
`endif

        // Random traffic: random digits every cycle and sparse random start pulses.
        // Some start pulses land while busy and must be ignored.
        for (int i = 0; i < 3000; i++) begin
            set_digits(4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                       4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                       4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)));
            start = ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end

        // start held high continuously restarts a conversion on every idle cycle.
        start = 1'b1;
        repeat (70) @(negedge clk);
        start = 1'b0;
        repeat (25) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
